// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/ack/status bundle between the vending controller, the dispenser and its mechanism
interface change_dispenser_if #(
    parameter int CNT_W = 4
);
    logic             can;
    logic [CNT_W-1:0] coin;
    logic             can_ack;
    logic             coin_ack;
    logic             jam_clr;
    logic             can_out;
    logic             coin_out;
    logic             busy;
    logic             done;
    logic             jam;
    logic             ovf;

    modport master (
        output can, coin, can_ack, coin_ack, jam_clr,
        input  can_out, coin_out, busy, done, jam, ovf
    );

    modport slave (
        input  can, coin, can_ack, coin_ack, jam_clr,
        output can_out, coin_out, busy, done, jam, ovf
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - queues can/coin requests and ejects them one item at a time with ack handshake and jam timeout
module change_dispenser #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CAN, S_COIN, S_GAP, S_DONE, S_JAM
    } state_t;

    localparam logic [CNT_W:0] COIN_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [TO_W-1:0]  tmo, tmo_nx;
    logic [1:0]       can_pend;
    logic [CNT_W-1:0] coin_pend;
    logic             can_dec, coin_dec;
    logic             ovf_q;
    logic [2:0]       can_sum;
    logic [CNT_W:0]   coin_sum;
    logic             can_sat, coin_sat;

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo;
        can_dec  = 1'b0;
        coin_dec = 1'b0;
        case (state)
            S_IDLE: begin
                tmo_nx = '0;
                if (can_pend != 2'd0)        state_nx = S_CAN;
                else if (coin_pend != '0)    state_nx = S_COIN;
            end
            S_CAN: begin
                if (bus.can_ack) begin
                    can_dec  = 1'b1;
                    tmo_nx   = '0;
                    state_nx = S_GAP;
                end else if (tmo == TMO_LAST) begin
                    tmo_nx   = '0;
                    state_nx = S_JAM;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            S_COIN: begin
                if (bus.coin_ack) begin
                    coin_dec = 1'b1;
                    tmo_nx   = '0;
                    state_nx = S_GAP;
                end else if (tmo == TMO_LAST) begin
                    tmo_nx   = '0;
                    state_nx = S_JAM;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            S_GAP: begin
                tmo_nx = '0;
                if (can_pend != 2'd0)        state_nx = S_CAN;
                else if (coin_pend != '0)    state_nx = S_COIN;
                else                         state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            S_JAM: begin
                tmo_nx = '0;
                if (bus.jam_clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Decrements only happen in an eject state, which is only entered with a non-zero count, so no underflow.
    always_comb begin
        can_sum  = {1'b0, can_pend} + {2'b00, bus.can} - {2'b00, can_dec};
        coin_sum = {1'b0, coin_pend} + {1'b0, bus.coin} - {{CNT_W{1'b0}}, coin_dec};
        can_sat  = (can_sum > 3'd3);
        coin_sat = (coin_sum > COIN_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmo       <= '0;
            can_pend  <= 2'd0;
            coin_pend <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            tmo       <= tmo_nx;
            can_pend  <= can_sat ? 2'd3 : can_sum[1:0];
            coin_pend <= coin_sat ? {CNT_W{1'b1}} : coin_sum[CNT_W-1:0];
            ovf_q     <= ovf_q | can_sat | coin_sat;
        end
    end

    assign bus.can_out  = (state == S_CAN);
    assign bus.coin_out = (state == S_COIN);
    assign bus.done     = (state == S_DONE);
    assign bus.jam      = (state == S_JAM);
    assign bus.busy     = (state != S_IDLE) || (can_pend != 2'd0) || (coin_pend != '0);
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector table plus hand-written jam/overflow/reset sequences
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if #(.CNT_W(4)) bus ();

    change_dispenser #(.CNT_W(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       can;
        logic [3:0] coin;
        logic       can_ack;
        logic       coin_ack;
        logic       jam_clr;
        logic [5:0] exp;   // {can_out, coin_out, done, jam, busy, ovf}
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic c, input logic [3:0] k, input logic ca, input logic ka,
                       input logic jc, input logic [5:0] e);
        vec_t v;
        v.can = c; v.coin = k; v.can_ack = ca; v.coin_ack = ka; v.jam_clr = jc; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic logic [5:0] outs();
        return {bus.can_out, bus.coin_out, bus.done, bus.jam, bus.busy, bus.ovf};
    endfunction

    // Acks each eject the cycle after it is seen; counts pulses until done or the budget runs out.
    task automatic run_acks(output int can_p, output int coin_p, output bit seen);
        logic pc, pk;
        can_p = 0; coin_p = 0; seen = 1'b0; pc = 1'b0; pk = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            bus.can_ack  = bus.can_out;
            bus.coin_ack = bus.coin_out;
            step();
            if (bus.can_out && !pc)  can_p++;
            if (bus.coin_out && !pk) coin_p++;
            pc = bus.can_out;
            pk = bus.coin_out;
            if (bus.done) seen = 1'b1;
        end
        bus.can_ack  = 1'b0;
        bus.coin_ack = 1'b0;
    endtask

    int cp, kp, hi;
    bit seen;

    initial begin
        bus.can = 1'b0; bus.coin = 4'd0; bus.can_ack = 1'b0; bus.coin_ack = 1'b0; bus.jam_clr = 1'b0;

        // single can, acked on its third cycle
        add(1, 0, 0, 0, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b100010);
        add(0, 0, 0, 0, 0, 6'b100010);
        add(0, 0, 0, 0, 0, 6'b100010);
        add(0, 0, 1, 0, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b001010);
        add(0, 0, 0, 0, 0, 6'b000000);
        // can + 3 coins together; can goes first; a stray can_ack during COIN is ignored
        add(1, 3, 0, 0, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b100010);
        add(0, 0, 0, 0, 0, 6'b100010);
        add(0, 0, 1, 0, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b010010);
        add(0, 0, 1, 0, 0, 6'b010010);
        add(0, 0, 0, 1, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b010010);
        add(0, 0, 0, 0, 0, 6'b010010);
        add(0, 0, 0, 1, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b010010);
        add(0, 0, 0, 0, 0, 6'b010010);
        add(0, 0, 0, 1, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b001010);
        add(0, 0, 0, 0, 0, 6'b000000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle[%0d]", i), {26'd0, outs()}, 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            bus.can = vecs[i].can; bus.coin = vecs[i].coin;
            bus.can_ack = vecs[i].can_ack; bus.coin_ack = vecs[i].coin_ack; bus.jam_clr = vecs[i].jam_clr;
            step();
            check($sformatf("vec[%0d]", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
        end
        bus.can = 1'b0; bus.coin = 4'd0; bus.can_ack = 1'b0; bus.coin_ack = 1'b0; bus.jam_clr = 1'b0;
        check("pend_after_table", {28'd0, dut.can_pend, 2'b00} | {28'd0, dut.coin_pend}, 32'd0);

        // new coins arrive in the same cycle the last pending coin is acked
        bus.coin = 4'd1; step();
        bus.coin = 4'd0; step();
        check("c_in_coin", {31'd0, bus.coin_out}, 32'd1);
        bus.coin = 4'd2; bus.coin_ack = 1'b1; step();
        bus.coin = 4'd0; bus.coin_ack = 1'b0;
        check("c_pend2", {28'd0, dut.coin_pend}, 32'd2);
        run_acks(cp, kp, seen);
        check("c_done", {31'd0, seen}, 32'd1);
        check("c_pulses", kp, 32'd2);
        check("c_cans", cp, 32'd0);

        // timeout: eject held exactly TIMEOUT cycles, then JAM keeps and queues work
        bus.coin = 4'd1; step();
        bus.coin = 4'd0;
        hi = 0;
        for (int i = 0; i < 40 && !bus.jam; i++) begin
            step();
            if (bus.coin_out) hi++;
        end
        check("t_high", hi, 32'd16);
        check("t_jam", {30'd0, bus.jam, bus.coin_out}, 32'd2);
        check("t_pend", {28'd0, dut.coin_pend}, 32'd1);
        bus.coin_ack = 1'b1; step();
        bus.coin_ack = 1'b0;
        check("t_ack_ignored", {28'd0, dut.coin_pend}, 32'd1);
        bus.coin = 4'd1; step();
        bus.coin = 4'd0;
        check("t_queue_in_jam", {27'd0, bus.jam, dut.coin_pend}, 32'h12);
        bus.jam_clr = 1'b1; step();
        bus.jam_clr = 1'b0;
        check("t_clr", {30'd0, bus.jam, bus.busy}, 32'd1);
        run_acks(cp, kp, seen);
        check("t_done", {31'd0, seen}, 32'd1);
        check("t_pulses", kp, 32'd2);
        check("t_pend0", {28'd0, dut.coin_pend}, 32'd0);

        // saturation then asynchronous reset mid-eject
        for (int i = 0; i < 4; i++) begin
            bus.coin = 4'd4; step();
        end
        bus.coin = 4'd0;
        check("s_pend15", {28'd0, dut.coin_pend}, 32'd15);
        check("s_ovf", {30'd0, bus.ovf, bus.coin_out}, 32'd3);
        step();
        check("s_ovf_sticky", {31'd0, bus.ovf}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("r_out", {26'd0, outs()}, 32'd0);
        check("r_pend", {28'd0, dut.coin_pend}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("r_idle", {26'd0, outs()}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending-machine controller. It consumes the controller's single-cycle `can` (dispense) and `coin[3:0]` (change count, in 10-unit coins) outputs.
- It drives the can solenoid and the change hopper one item at a time, using an eject/ack handshake per item.
- Requests are queued while the mechanism is busy. Timeouts flag a jam, and no request is lost.

Parameters:
- CNT_W, 4: width of the pending-coin counter and the `coin` input.
- TIMEOUT, 16: cycles an eject may stay asserted without an ack before a jam is declared (valid range 2..255).
- TO_W, $clog2(TIMEOUT+1): width of the timeout counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- can  in  1  dispense-can request, sampled every cycle
- coin  in  CNT_W  coins to return, sampled every cycle (0 = none)
- can_ack  in  1  can-chute sensor; high for ≥1 cycle when a can drops
- coin_ack  in  1  hopper sensor; high for ≥1 cycle when a coin drops
- jam_clr  in  1  operator clear, leaves JAM
- can_out  out  1  can solenoid drive
- coin_out  out  1  hopper motor drive, one coin per assertion
- busy  out  1  state != IDLE or any count pending
- done  out  1  one-cycle pulse when all queued work completes
- jam  out  1  high while in JAM
- ovf  out  1  sticky; a request saturated a counter

Behaviour:
- Reset (rst low, async): state=IDLE, can_pend=0, coin_pend=0, tmo=0, ovf=0. All outputs read 0.
- Queueing, every rising edge:
  - can_pend (2 bits) is updated as can_pend + can − can_dec.
  - coin_pend (CNT_W bits) is updated as coin_pend + coin − coin_dec.
  - can_dec and coin_dec are the 1-cycle ack decrements defined below.
  - Simultaneous increment and decrement apply together in the same cycle.
  - Results saturate at the counter maximum (3 and 2^CNT_W−1). Any saturation sets ovf, which clears only on reset.
- Request latency: a request sampled at edge E0 updates the pending counts at E0. The FSM leaves IDLE at E1, and the eject output is high from E1.
- FSM states: IDLE, CAN, COIN, GAP, DONE, JAM.
- IDLE:
  - if can_pend>0 → CAN
  - else if coin_pend>0 → COIN
  - Cans always take priority over coins.
- CAN:
  - can_out=1 throughout; tmo increments each cycle.
  - On can_ack=1: can_dec=1, tmo=0, next state GAP.
  - If tmo reaches TIMEOUT−1 with no ack: next state JAM.
- COIN:
  - coin_out=1 throughout; tmo increments each cycle.
  - On coin_ack=1: coin_dec=1, tmo=0, next state GAP.
  - Timeout is handled as in CAN → JAM.
- GAP:
  - One cycle with all outputs low, so every eject is a distinct pulse.
  - Next state: CAN if can_pend>0, else COIN if coin_pend>0, else DONE.
- DONE: done=1 for one cycle, then → IDLE.
  - If new work arrived during DONE, IDLE dispatches it on the next cycle.
- JAM:
  - jam=1; can_out=0 and coin_out=0; tmo=0.
  - Pending counts are retained and new requests still queue.
  - Leaves JAM only on jam_clr=1 → IDLE, which resumes the queued work.
  - An ack arriving in JAM is ignored and does not decrement.
- Ack rules:
  - An ack is honoured only in the matching eject state.
  - can_ack in COIN is ignored, and vice versa.
  - An ack held high for several cycles counts once, because the FSM moves to GAP on the first one.
- Outputs can_out, coin_out, jam and done are decoded from the state register (glitch-free, no combinational path from inputs). busy is registered-state based.
- Reset mid-eject drops the eject output immediately and discards all pending work.

Test Plan:
- Reset then idle for 20 cycles → all outputs 0; busy=0.
- can=1 for one cycle, can_ack pulsed 3 cycles after can_out rises → can_out high 3 cycles, then GAP, then done pulse; can_pend=0.
- coin=3 with can=1 in the same cycle; ack each eject after 2 cycles → sequence CAN, GAP, COIN, GAP, COIN, GAP, COIN, GAP, DONE; exactly 1 can_out and 3 coin_out pulses.
- coin=2 arrives while a COIN eject is acked in the same cycle, with coin_pend=1 → coin_pend becomes 2; two further coin pulses follow.
- No ack with TIMEOUT=16 → coin_out high exactly 16 cycles, then jam=1 with counts retained; jam_clr → eject resumes; on completion done=1.
- coin=4 on four consecutive cycles (16 > 15) → coin_pend=15 and ovf=1; rst asserted mid-COIN → coin_out=0 immediately and counts=0.
